adc_frame_capture: RTL and testbench

Serial ADC capture stage for the 3LFCC control loop. It sits directly downstream of the control-loop sample timer. On each single-cycle `trigger_i` pulse it runs one 16-bit SPI read frame from a 12-bit ADC with 4 leading zeros, and presents the 12-bit result. It then returns a single-cycle `eoc_o` pulse, which feeds the timer's end-of-conversion input and closes the sampling loop.

---
 rtl/adc_frame_capture.sv | 146 ++++++++++++++
 tb/tb_adc_frame_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_capture.sv
// SPI read-frame engine for a 12-bit ADC (16-bit frame, 4 leading zeros).
// One frame per accepted trigger; eoc_o closes the sample-timer loop.
module adc_frame_capture #(
    parameter int unsigned ClkDiv      = 2,
    parameter int unsigned QuietCycles = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trigger_i,
    input  logic        adc_sdo_i,
    output logic        adc_cs_no,
    output logic        adc_sclk_o,
    output logic [11:0] data_o,
    output logic        eoc_o,
    output logic        frame_err_o,
    output logic        busy_o,
    output logic        missed_o
);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StQuiet} state_e;

    localparam logic [7:0] DivLast   = 8'(ClkDiv - 1);
    localparam logic [7:0] QuietLast = 8'(QuietCycles - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic [11:0] data_q, data_d;
    logic        eoc_q, eoc_d;
    logic        err_q, err_d;
    logic        missed_q, missed_d;
    logic        div_end;
    logic        accept;

    assign div_end = (div_q == DivLast);
    // The edge that completes QUIET is also an acceptance edge, so back-to-back
    // frames need no idle gap.
    assign accept  = trigger_i &&
                     ((state_q == StIdle) || ((state_q == StQuiet) && (div_q == QuietLast)));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        data_d   = data_q;
        err_d    = err_q;
        eoc_d    = 1'b0;
        missed_d = trigger_i && !accept;

        unique case (state_q)
            StIdle: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                if (accept) begin
                    state_d = StSetup;
                    cs_d    = 1'b0;
                    div_d   = 8'd0;
                end
            end
            StSetup: begin
                if (div_end) begin
                    state_d = StShift;
                    sclk_d  = 1'b0;
                    bit_d   = 5'd0;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StShift: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[14:0], adc_sdo_i};
                        bit_d   = bit_q + 5'd1;
                    end else if (bit_q == 5'd16) begin
                        state_d = StQuiet;
                        cs_d    = 1'b1;
                        data_d  = shift_q[11:0];
                        err_d   = |shift_q[15:12];
                        eoc_d   = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            StQuiet: begin
                if (div_q == QuietLast) begin
                    state_d = StIdle;
                    div_d   = 8'd0;
                    if (accept) begin
                        state_d = StSetup;
                        cs_d    = 1'b0;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            div_q    <= 8'd0;
            bit_q    <= 5'd0;
            shift_q  <= 16'd0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            data_q   <= 12'd0;
            eoc_q    <= 1'b0;
            err_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            data_q   <= data_d;
            eoc_q    <= eoc_d;
            err_q    <= err_d;
            missed_q <= missed_d;
        end
    end

    assign adc_cs_no   = cs_q;
    assign adc_sclk_o  = sclk_q;
    assign data_o      = data_q;
    assign eoc_o       = eoc_q;
    assign frame_err_o = err_q;
    assign busy_o      = (state_q != StIdle);
    assign missed_o    = missed_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: default-parameter instance plus a
// ClkDiv=1/QuietCycles=1 instance, each driven by a behavioural ADC.
module tb_adc_frame_capture;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        trigger = 1'b0, trigger_f = 1'b0;
    logic        adc_sdo, sdo_f;
    logic        adc_cs_n, adc_sclk, eoc, frame_err, busy, missed;
    logic        cs_f, sclk_f, eoc_f, err_f, busy_f, missed_f;
    logic [11:0] data, data_f;

    int tests = 0;
    int failed = 0;

    always #5 clk_i = ~clk_i;

    adc_frame_capture u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .trigger_i  (trigger),
        .adc_sdo_i  (adc_sdo),
        .adc_cs_no  (adc_cs_n),
        .adc_sclk_o (adc_sclk),
        .data_o     (data),
        .eoc_o      (eoc),
        .frame_err_o(frame_err),
        .busy_o     (busy),
        .missed_o   (missed)
    );

    adc_frame_capture #(.ClkDiv(1), .QuietCycles(1)) u_dut_fast (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .trigger_i  (trigger_f),
        .adc_sdo_i  (sdo_f),
        .adc_cs_no  (cs_f),
        .adc_sclk_o (sclk_f),
        .data_o     (data_f),
        .eoc_o      (eoc_f),
        .frame_err_o(err_f),
        .busy_o     (busy_f),
        .missed_o   (missed_f)
    );

    // ADC models: MSB presented at CS fall, next bit after each SCLK rise.
    logic [15:0] word_m = 16'd0, word_f = 16'd0;
    logic [7:0]  rise_m = 8'd0, base_m = 8'd0, rise_f = 8'd0, base_f = 8'd0;
    logic [7:0]  idx_m, idx_f;

    always @(posedge adc_sclk) if (!adc_cs_n) rise_m <= rise_m + 8'd1;
    always @(negedge adc_cs_n) base_m <= rise_m;
    always @(posedge sclk_f) if (!cs_f) rise_f <= rise_f + 8'd1;
    always @(negedge cs_f) base_f <= rise_f;

    assign idx_m   = rise_m - base_m;
    assign idx_f   = rise_f - base_f;
    assign adc_sdo = (idx_m < 8'd16) ? word_m[4'(8'd15 - idx_m)] : 1'b0;
    assign sdo_f   = (idx_f < 8'd16) ? word_f[4'(8'd15 - idx_f)] : 1'b0;

    typedef struct {
        logic [15:0] word;
        logic [11:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [15:0] w, input logic [11:0] exp_d, input logic exp_e);
        int lat;
        word_m  = w;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("cs_low_after_trigger", 32'(adc_cs_n), 32'd0);
        lat = 0;
        while (!eoc && lat < 200) begin
            step();
            lat++;
        end
        check("eoc_latency", lat, 32'd66);
        check("data", 32'(data), 32'(exp_d));
        check("frame_err", 32'(frame_err), 32'(exp_e));
        check("sclk_rises", 32'(idx_m), 32'd16);
        check("cs_high_at_eoc", 32'(adc_cs_n), 32'd1);
        step();
        check("eoc_width", 32'(eoc), 32'd0);
        check("busy_in_quiet", 32'(busy), 32'd1);
        step();
        check("busy_idle", 32'(busy), 32'd0);
        check("data_hold", 32'(data), 32'(exp_d));
    endtask

    initial begin
        int n_eoc, n_miss, eoc_at[2], miss_at[2], lat, last, bad_per;

        vecs[0] = '{16'h0A5C, 12'hA5C, 1'b0};
        vecs[1] = '{16'h8123, 12'h123, 1'b1};
        vecs[2] = '{16'h0FFF, 12'hFFF, 1'b0};
        vecs[3] = '{16'h1000, 12'h000, 1'b1};
        vecs[4] = '{16'h0001, 12'h001, 1'b0};

        #2 rst_ni = 1'b0;
        #1;
        check("rst_cs", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd1);
        check("rst_data", 32'(data), 32'd0);
        check("rst_eoc", 32'(eoc), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_frame(vecs[i].word, vecs[i].data, vecs[i].err);

        // Triggers at T, T+10, T+67 (QUIET) and T+68 (QUIET completing: accepted).
        n_eoc = 0;
        n_miss = 0;
        eoc_at = '{-1, -1};
        miss_at = '{-1, -1};
        word_m = 16'h0321;
        for (int c = 0; c <= 140; c++) begin
            trigger = (c == 0 || c == 10 || c == 67 || c == 68);
            step();
            trigger = 1'b0;
            if (eoc) begin
                if (n_eoc < 2) eoc_at[n_eoc] = c;
                n_eoc++;
            end
            if (missed) begin
                if (n_miss < 2) miss_at[n_miss] = c;
                n_miss++;
            end
        end
        check("busy_missed_count", n_miss, 32'd2);
        check("busy_missed_first", miss_at[0], 32'd10);
        check("busy_missed_second", miss_at[1], 32'd67);
        check("busy_eoc_count", n_eoc, 32'd2);
        check("busy_eoc_first", eoc_at[0], 32'd66);
        check("busy_eoc_second", eoc_at[1], 32'd134);
        check("busy_data", 32'(data), 32'h321);
        repeat (5) step();

        // Reset mid-frame.
        word_m  = 16'h0ABC;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (30) step();
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_cs", 32'(adc_cs_n), 32'd1);
        check("midrst_sclk", 32'(adc_sclk), 32'd1);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        step();
        rst_ni = 1'b1;
        n_eoc = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (eoc || busy) n_eoc++;
        end
        check("midrst_no_resume", n_eoc, 32'd0);
        run_frame(16'h0ABC, 12'hABC, 1'b0);

        // Sample timer with period 100 closing the loop through eoc.
        n_eoc = 0;
        n_miss = 0;
        last = -1;
        bad_per = 0;
        word_m = 16'h0456;
        for (int c = 0; c < 1000; c++) begin
            trigger = (c % 100 == 0);
            step();
            trigger = 1'b0;
            if (eoc) begin
                if (last >= 0 && c - last != 100) bad_per++;
                last = c;
                n_eoc++;
            end
            if (missed) n_miss++;
        end
        check("loop_eoc_count", n_eoc, 32'd10);
        check("loop_missed", n_miss, 32'd0);
        check("loop_period", bad_per, 32'd0);
        check("loop_data", 32'(data), 32'h456);

        // ClkDiv=1, QuietCycles=1 corner.
        word_f    = 16'h0555;
        trigger_f = 1'b1;
        step();
        trigger_f = 1'b0;
        lat = 0;
        while (!eoc_f && lat < 100) begin
            step();
            lat++;
        end
        check("fast_eoc_latency", lat, 32'd33);
        check("fast_data", 32'(data_f), 32'h555);
        check("fast_err", 32'(err_f), 32'd0);
        check("fast_sclk_rises", 32'(idx_f), 32'd16);
        step();
        check("fast_eoc_width", 32'(eoc_f), 32'd0);
        check("fast_idle", 32'(busy_f), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
